cond_flag_unit: RTL and testbench

- Consumer end of the ALU's N/Z/C/V flag interface: holds the architectural condition flags (CPSR[31:28]), updates them from ALU results on S-bit instructions, and feeds the stored C back as the ALU carryIn.
- Evaluates the 4-bit ARM condition field of issued instructions against the flags and returns a registered pass/fail verdict over a valid/ready handshake.
- Sits between the decode/issue stage and the execute/writeback stage.

---
 rtl/cond_flag_unit.sv | 193 +++++++++++++++++++
 tb/tb_cond_flag_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_flag_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cond_flag_unit
//  Description : Holds the architectural N/Z/C/V condition flags, updates them
//                from ALU results on flag-setting instructions, and feeds the
//                stored C back to the ALU as carry_in. It evaluates the 4-bit
//                ARM condition field of issued instructions against the flags.
//                The verdict is returned through a single-entry registered
//                valid/ready stage. Saturating pass/fail statistics counters
//                are also kept.
//  Ports       : clk, rst_n             - clock, async active-low reset
//                upd_*, alu_*, shift_c  - flag update from the ALU
//                ev_valid/ev_ready/ev_cond/ev_tag - evaluation request
//                ex_valid/ex_ready/ex_pass/ex_tag - registered verdict
//                flags, carry_in        - stored {N,Z,C,V} and stored C
//                pass_cnt, fail_cnt     - delivered verdict statistics
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_flag_unit #(
    parameter bit FWD_EN = 1'b1,
    parameter int TAG_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd_valid,
    input  logic [3:0]       upd_opcode,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v,
    input  logic             shift_c,
    input  logic             ev_valid,
    output logic             ev_ready,
    input  logic [3:0]       ev_cond,
    input  logic [TAG_W-1:0] ev_tag,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic             ex_pass,
    output logic [TAG_W-1:0] ex_tag,
    output logic [3:0]       flags,
    output logic             carry_in,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam logic [0:0]       c_s_empty = 1'b0;
    localparam logic [0:0]       c_s_full  = 1'b1;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       r_flags;
    logic [3:0]       w_upd_flags;
    logic [3:0]       w_eff_flags;
    logic             w_arith;
    logic             w_cond_ok;
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             w_accept;
    logic             w_deliver;
    logic             r_pass;
    logic [TAG_W-1:0] r_tag;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;

    // ------------------------------------------------------------------
    // Flag update. Arithmetic opcodes (SUB..RSC, CMP, CMN) write all four
    // flags. Every other opcode is logical: C comes from the shifter and
    // V is preserved. w_upd_flags equals r_flags when no update is present,
    // so it doubles as the forwarded flag value.
    // ------------------------------------------------------------------
    always_comb begin
        w_arith = 1'b0;
        case (upd_opcode)
            4'b0010, 4'b0011, 4'b0100, 4'b0101,
            4'b0110, 4'b0111, 4'b1010, 4'b1011: w_arith = 1'b1;
            default:                            w_arith = 1'b0;
        endcase

        w_upd_flags = r_flags;
        if (upd_valid) begin
            if (w_arith) begin
                w_upd_flags = {alu_n, alu_z, alu_c, alu_v};
            end else begin
                w_upd_flags = {alu_n, alu_z, shift_c, r_flags[0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
        end else begin
            r_flags <= w_upd_flags;
        end
    end

    generate
        if (FWD_EN) begin : g_fwd
            assign w_eff_flags = w_upd_flags;
        end else begin : g_no_fwd
            assign w_eff_flags = r_flags;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Condition decode against the flags in effect
    // ------------------------------------------------------------------
    always_comb begin
        logic w_n, w_z, w_c, w_v;
        {w_n, w_z, w_c, w_v} = w_eff_flags;
        w_cond_ok = 1'b0;
        case (ev_cond)
            4'b0000: w_cond_ok = w_z;
            4'b0001: w_cond_ok = !w_z;
            4'b0010: w_cond_ok = w_c;
            4'b0011: w_cond_ok = !w_c;
            4'b0100: w_cond_ok = w_n;
            4'b0101: w_cond_ok = !w_n;
            4'b0110: w_cond_ok = w_v;
            4'b0111: w_cond_ok = !w_v;
            4'b1000: w_cond_ok = w_c && !w_z;
            4'b1001: w_cond_ok = !w_c || w_z;
            4'b1010: w_cond_ok = (w_n == w_v);
            4'b1011: w_cond_ok = (w_n != w_v);
            4'b1100: w_cond_ok = !w_z && (w_n == w_v);
            4'b1101: w_cond_ok = w_z || (w_n != w_v);
            4'b1110: w_cond_ok = 1'b1;
            default: w_cond_ok = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Single-entry output stage. The ready signal depends only on the
    // stage occupancy and downstream ready. This allows a full stage to
    // reload in the same cycle it drains.
    // ------------------------------------------------------------------
    assign ev_ready  = (r_state == c_s_empty) || ex_ready;
    assign w_accept  = ev_valid && ev_ready;
    assign w_deliver = (r_state == c_s_full) && ex_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_s_empty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_s_empty: if (w_accept) w_state_nxt = c_s_full;
            c_s_full:  if (ex_ready && !w_accept) w_state_nxt = c_s_empty;
            default:   w_state_nxt = c_s_empty;
        endcase
    end

    // The verdict is captured only on accept. A stalled entry keeps its
    // original result even if the flags change underneath it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass <= 1'b0;
            r_tag  <= '0;
        end else if (w_accept) begin
            r_pass <= w_cond_ok;
            r_tag  <= ev_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
        end else if (w_deliver) begin
            if (r_pass) begin
                if (r_pass_cnt != c_cnt_max) r_pass_cnt <= r_pass_cnt + c_cnt_one;
            end else begin
                if (r_fail_cnt != c_cnt_max) r_fail_cnt <= r_fail_cnt + c_cnt_one;
            end
        end
    end

    assign ex_valid = (r_state == c_s_full);
    assign ex_pass  = r_pass;
    assign ex_tag   = r_tag;
    assign flags    = r_flags;
    assign carry_in = r_flags[1];
    assign pass_cnt = r_pass_cnt;
    assign fail_cnt = r_fail_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cond_flag_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cond_flag_unit
//  Description : Self-checking bench. It drives two instances with shared
//                stimulus. Instance a uses forwarding and 16-bit counters.
//                Instance b has no forwarding and uses 3-bit counters, so
//                counter saturation is reachable. Both are compared against
//                a behavioural model on every cycle, alongside directed
//                literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_flag_unit;

    localparam int TAG_W = 8;
    localparam int CW0   = 16;
    localparam int CW1   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic             upd_valid = 1'b0;
    logic [3:0]       upd_opcode = '0;
    logic             alu_n = 0, alu_z = 0, alu_c = 0, alu_v = 0, shift_c = 0;
    logic             ev_valid = 1'b0;
    logic [3:0]       ev_cond = '0;
    logic [TAG_W-1:0] ev_tag = '0;
    logic             ex_ready = 1'b1;

    logic             a_ev_ready, a_ex_valid, a_ex_pass, a_carry;
    logic [TAG_W-1:0] a_ex_tag;
    logic [3:0]       a_flags;
    logic [CW0-1:0]   a_pass_cnt, a_fail_cnt;
    logic             b_ev_ready, b_ex_valid, b_ex_pass, b_carry;
    logic [TAG_W-1:0] b_ex_tag;
    logic [3:0]       b_flags;
    logic [CW1-1:0]   b_pass_cnt, b_fail_cnt;

    cond_flag_unit #(.FWD_EN(1'b1), .TAG_W(TAG_W), .CNT_W(CW0)) u_a (
        .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_opcode(upd_opcode),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .shift_c(shift_c),
        .ev_valid(ev_valid), .ev_ready(a_ev_ready), .ev_cond(ev_cond), .ev_tag(ev_tag),
        .ex_valid(a_ex_valid), .ex_ready(ex_ready), .ex_pass(a_ex_pass), .ex_tag(a_ex_tag),
        .flags(a_flags), .carry_in(a_carry), .pass_cnt(a_pass_cnt), .fail_cnt(a_fail_cnt)
    );

    cond_flag_unit #(.FWD_EN(1'b0), .TAG_W(TAG_W), .CNT_W(CW1)) u_b (
        .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_opcode(upd_opcode),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .shift_c(shift_c),
        .ev_valid(ev_valid), .ev_ready(b_ev_ready), .ev_cond(ev_cond), .ev_tag(ev_tag),
        .ex_valid(b_ex_valid), .ex_ready(ex_ready), .ex_pass(b_ex_pass), .ex_tag(b_ex_tag),
        .flags(b_flags), .carry_in(b_carry), .pass_cnt(b_pass_cnt), .fail_cnt(b_fail_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [3:0] model_update(input logic [3:0] f, input logic [3:0] op,
                                                input logic n, z, c, v, sc);
        if (op inside {[4'd2:4'd7], 4'd10, 4'd11}) return {n, z, c, v};
        return {n, z, sc, f[0]};
    endfunction

    function automatic logic model_cond(input logic [3:0] cd, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cd)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    logic [3:0]       mf [2];
    logic [3:0]       mn [2];
    logic             mv;
    logic [TAG_W-1:0] mt;
    logic             mp [2];
    int               mpc [2];
    int               mfc [2];
    int               mmax [2];
    logic             m_rdy;

    assign mmax[0] = (1 << CW0) - 1;
    assign mmax[1] = (1 << CW1) - 1;
    assign m_rdy   = !mv || ex_ready;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            mn[i] = upd_valid ? model_update(mf[i], upd_opcode, alu_n, alu_z, alu_c, alu_v, shift_c)
                              : mf[i];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mf[i]  <= 4'b0000;
                mp[i]  <= 1'b0;
                mpc[i] <= 0;
                mfc[i] <= 0;
            end
            mv <= 1'b0;
            mt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                mf[i] <= mn[i];
                if (mv && ex_ready) begin
                    if (mp[i]) mpc[i] <= (mpc[i] < mmax[i]) ? mpc[i] + 1 : mpc[i];
                    else       mfc[i] <= (mfc[i] < mmax[i]) ? mfc[i] + 1 : mfc[i];
                end
            end
            if (ev_valid && m_rdy) begin
                mv    <= 1'b1;
                mt    <= ev_tag;
                mp[0] <= model_cond(ev_cond, mn[0]);  // forwarded flags
                mp[1] <= model_cond(ev_cond, mf[1]);  // stored flags
            end else if (ex_ready) begin
                mv <= 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("a_flags",    a_flags,    mf[0]);
            chk("a_carry_in", a_carry,    mf[0][1]);
            chk("a_ev_ready", a_ev_ready, m_rdy);
            chk("a_ex_valid", a_ex_valid, mv);
            chk("a_pass_cnt", a_pass_cnt, mpc[0]);
            chk("a_fail_cnt", a_fail_cnt, mfc[0]);
            chk("b_flags",    b_flags,    mf[1]);
            chk("b_carry_in", b_carry,    mf[1][1]);
            chk("b_ev_ready", b_ev_ready, m_rdy);
            chk("b_ex_valid", b_ex_valid, mv);
            chk("b_pass_cnt", b_pass_cnt, mpc[1]);
            chk("b_fail_cnt", b_fail_cnt, mfc[1]);
            if (mv) begin
                chk("a_ex_pass", a_ex_pass, mp[0]);
                chk("a_ex_tag",  a_ex_tag,  mt);
                chk("b_ex_pass", b_ex_pass, mp[1]);
                chk("b_ex_tag",  b_ex_tag,  mt);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_upd(input logic [3:0] op, input logic [3:0] nzcv, input logic sc);
        upd_valid  = 1'b1;
        upd_opcode = op;
        {alu_n, alu_z, alu_c, alu_v} = nzcv;
        shift_c    = sc;
    endtask

    logic [15:0] pass_mask;

    initial begin
        #1 rst_n = 1'b0;
        step();
        step();
        chk("rst_flags",    a_flags,    4'b0000);
        chk("rst_carry",    a_carry,    1'b0);
        chk("rst_ex_valid", a_ex_valid, 1'b0);
        chk("rst_ex_pass",  a_ex_pass,  1'b0);
        chk("rst_ex_tag",   a_ex_tag,   8'h00);
        chk("rst_cnts",     {a_pass_cnt, a_fail_cnt}, 32'h0);
        rst_n = 1'b1;
        step();

        // Arithmetic update, followed by EQ
        set_upd(4'b0100, 4'b0110, 1'b0);
        step();
        upd_valid = 1'b0;
        chk("t1_flags", a_flags, 4'b0110);
        chk("t1_carry", a_carry, 1'b1);
        ev_valid = 1'b1; ev_cond = 4'b0000; ev_tag = 8'h11;
        step();
        ev_valid = 1'b0;
        chk("t1_valid", a_ex_valid, 1'b1);
        chk("t1_pass",  a_ex_pass,  1'b1);
        chk("t1_tag",   a_ex_tag,   8'h11);
        step();

        // Logical update preserves V; C is taken from shift_c, not alu_c
        set_upd(4'b0010, 4'b0011, 1'b0);
        step();
        set_upd(4'b1100, 4'b1010, 1'b0);
        step();
        upd_valid = 1'b0;
        chk("t2_flags", a_flags, 4'b1001);
        ev_valid = 1'b1; ev_cond = 4'b1010; ev_tag = 8'h21;
        step();
        chk("t2_ge", a_ex_pass, 1'b1);
        ev_cond = 4'b1100; ev_tag = 8'h22;
        step();
        ev_valid = 1'b0;
        chk("t2_gt", a_ex_pass, 1'b1);
        step();

        // Forwarding: update and evaluation in the same cycle
        set_upd(4'b0010, 4'b0000, 1'b0);
        step();
        set_upd(4'b0010, 4'b0100, 1'b0);
        ev_valid = 1'b1; ev_cond = 4'b0000; ev_tag = 8'h31;
        step();
        upd_valid = 1'b0; ev_valid = 1'b0;
        chk("t3_fwd_pass",   a_ex_pass, 1'b1);
        chk("t3_nofwd_pass", b_ex_pass, 1'b0);
        step();

        // Stall for three cycles; a flag change must not alter the held verdict
        ex_ready = 1'b0;
        ev_valid = 1'b1; ev_cond = 4'b0000; ev_tag = 8'h41;
        step();
        ev_tag = 8'h42;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) set_upd(4'b0010, 4'b1010, 1'b0);
            else        upd_valid = 1'b0;
            step();
            chk("t4_ready", a_ev_ready, 1'b0);
            chk("t4_tag",   a_ex_tag,   8'h41);
            chk("t4_pass",  a_ex_pass,  1'b1);
        end
        upd_valid = 1'b0;
        ex_ready = 1'b1;
        step();
        ev_valid = 1'b0;
        chk("t4_next_tag",  a_ex_tag,  8'h42);
        chk("t4_next_pass", a_ex_pass, 1'b0);
        step();
        chk("t4_drained", a_ex_valid, 1'b0);

        // All sixteen conditions against N=1 Z=0 C=1 V=0.
        // Passing set: NE CS MI VC HI LT LE AL
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_upd(4'b0010, 4'b1010, 1'b0);
        step();
        upd_valid = 1'b0;
        pass_mask = 16'h6996;
        ev_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ev_cond = 4'(i);
            ev_tag  = 8'(8'h50 + i);
            step();
            chk("t5_pass", a_ex_pass, pass_mask[i]);
        end
        ev_valid = 1'b0;
        step();
        chk("t5_pass_cnt",     a_pass_cnt, 16'd8);
        chk("t5_fail_cnt",     a_fail_cnt, 16'd8);
        chk("t5_sat_pass_cnt", b_pass_cnt, 3'd7);
        chk("t5_sat_fail_cnt", b_fail_cnt, 3'd7);

        // Asynchronous reset while FULL
        ex_ready = 1'b0;
        ev_valid = 1'b1; ev_cond = 4'b1110; ev_tag = 8'h61;
        step();
        ev_valid = 1'b0;
        chk("t6_full", a_ex_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_ex_valid", a_ex_valid, 1'b0);
        chk("t6_flags",    a_flags,    4'b0000);
        chk("t6_cnts",     {a_pass_cnt, a_fail_cnt}, 32'h0);
        chk("t6_b_valid",  b_ex_valid, 1'b0);
        step();
        rst_n = 1'b1;
        ex_ready = 1'b1;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
